// File: rtl/approx_mult_pkg.sv
// Shared defaults and width helper for the approximate multiplier pipeline.
// Everything here is elaboration-time only.
package approx_mult_pkg;

  localparam int W_DEF      = 8;
  localparam int L_DEF      = 2;
  localparam int STAGES_DEF = 2;
  localparam int CNTW_DEF   = 16;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/approx_mult_if.sv
// Operand/result handshake bundle for approx_mult_pipe.
// The slave side is the multiplier; the master side is the producer/consumer pair.
interface approx_mult_if import approx_mult_pkg::*; #(
  parameter int W    = W_DEF,
  parameter int CNTW = CNTW_DEF
);

  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           x;
  logic [W-1:0]           y;
  logic                   approx_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [prod_w(W)-1:0]   z;
  logic                   z_approx;
  logic [CNTW-1:0]        approx_cnt;

  modport master (
    output in_valid, x, y, approx_en, out_ready,
    input  in_ready, out_valid, z, z_approx, approx_cnt
  );

  modport slave (
    input  in_valid, x, y, approx_en, out_ready,
    output in_ready, out_valid, z, z_approx, approx_cnt
  );

endinterface

// File: rtl/approx_pp_corr.sv
// Combinational correction term for the L dropped low multiplier rows.
// High-weight bits kept exactly, the weight-(W-2) column collapsed to a single OR bit.
module approx_pp_corr import approx_mult_pkg::*; #(
  parameter int  W  = W_DEF,
  parameter int  L  = L_DEF,
  localparam int LW = (L > 0) ? L : 1,
  localparam int PW = prod_w(W)
) (
  input  logic [LW-1:0] x_lo,
  input  logic [W-1:0]  y,
  output logic [PW-1:0] c
);

  logic [PW-1:0] acc;
  logic          or_bit;

  always_comb begin
    acc    = '0;
    or_bit = 1'b0;
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < W; j++) begin
        if (x_lo[i] && y[j]) begin
          if (i + j >= W - 1) begin
            acc = acc + (PW'(1) << (i + j));
          end else if (i + j == W - 2) begin
            or_bit = 1'b1;
          end
        end
      end
    end
    // The OR of the W-2 column stands in for the carry the dropped columns would produce.
    c = acc + (PW'(or_bit) << (W - 1));
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined exact/approximate unsigned multiplier, STAGES cycles latency.
// Global stall when the result is held (out_valid & ~out_ready); in_ready drops only then.
module approx_mult_pipe import approx_mult_pkg::*; #(
  parameter int W      = W_DEF,
  parameter int L      = L_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  approx_mult_if.slave bus
);

  localparam int PW = prod_w(W);
  localparam int LW = (L > 0) ? L : 1;

  logic              stall;
  logic              in_fire;
  logic              out_fire;
  logic [STAGES-1:0] vld_q;
  logic [PW-1:0]     hi_d;
  logic [PW-1:0]     c_d;
  logic [PW-1:0]     res_z;
  logic              res_approx;
  logic [CNTW-1:0]   cnt_q;

  assign stall    = vld_q[STAGES-1] & ~bus.out_ready;
  assign in_fire  = bus.in_valid & ~stall;
  assign out_fire = vld_q[STAGES-1] & bus.out_ready;

  // Rows L and above multiply exactly; the low rows come back through the correction term.
  assign hi_d = (PW'(bus.y) * PW'(bus.x >> L)) << L;

  approx_pp_corr #(
    .W (W),
    .L (L)
  ) u_corr (
    .x_lo (bus.x[LW-1:0]),
    .y    (bus.y),
    .c    (c_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (!stall) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_q[k] <= vld_q[k-1];
      end
      vld_q[0] <= in_fire;
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      logic [PW-1:0] z_q;
      logic          za_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          z_q  <= '0;
          za_q <= 1'b0;
        end else if (in_fire) begin
          z_q  <= bus.approx_en ? (hi_d + c_d) : (PW'(bus.x) * PW'(bus.y));
          za_q <= bus.approx_en;
        end
      end

      assign res_z      = z_q;
      assign res_approx = za_q;
    end else begin : g_multi
      logic [W-1:0]  x_q;
      logic [W-1:0]  y_q;
      logic          mode_q;
      logic [PW-1:0] hi_q;
      logic [PW-1:0] c_q;
      logic [PW-1:0] sum_d;
      logic [PW-1:0] zp_q [STAGES-1];
      logic          ap_q [STAGES-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_q    <= '0;
          y_q    <= '0;
          mode_q <= 1'b0;
          hi_q   <= '0;
          c_q    <= '0;
        end else if (in_fire) begin
          x_q    <= bus.x;
          y_q    <= bus.y;
          mode_q <= bus.approx_en;
          hi_q   <= hi_d;
          c_q    <= c_d;
        end
      end

      assign sum_d = mode_q ? (hi_q + c_q) : (PW'(x_q) * PW'(y_q));

      // Data registers load only behind a valid bit so bubbles leave the held result untouched.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < STAGES - 1; k++) begin
            zp_q[k] <= '0;
            ap_q[k] <= 1'b0;
          end
        end else if (!stall) begin
          if (vld_q[0]) begin
            zp_q[0] <= sum_d;
            ap_q[0] <= mode_q;
          end
          for (int k = 1; k < STAGES - 1; k++) begin
            if (vld_q[k]) begin
              zp_q[k] <= zp_q[k-1];
              ap_q[k] <= ap_q[k-1];
            end
          end
        end
      end

      assign res_z      = zp_q[STAGES-2];
      assign res_approx = ap_q[STAGES-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_fire && res_approx) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign bus.in_ready   = ~stall;
  assign bus.out_valid  = vld_q[STAGES-1];
  assign bus.z          = res_z;
  assign bus.z_approx   = res_approx;
  assign bus.approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed table, stall/reset sequences, random streams.
module tb_approx_mult_pipe;

  localparam int W      = 8;
  localparam int L      = 2;
  localparam int STAGES = 2;
  localparam int CNTW   = 4;
  localparam int PW     = 2 * W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  approx_mult_if #(.W(W), .CNTW(CNTW)) bus ();

  approx_mult_pipe #(
    .W      (W),
    .L      (L),
    .STAGES (STAGES),
    .CNTW   (CNTW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int z;
    bit a;
    int cyc;
  } exp_t;

  typedef struct {
    int x;
    int y;
    bit ae;
    int ez;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[13];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          cnt_m   = 0;
  int          n_pop   = 0;
  bit          lat_chk = 1'b0;
  bit          stall_prev = 1'b0;
  logic [PW-1:0] z_prev = '0;
  logic        za_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: high rows by plain multiply, low rows as "bits of y that land at >= W-1" plus one OR bit.
  function automatic int ref_prod(input int xv, input int yv, input bit ae);
    int  hi;
    int  c;
    bit  orb;
    if (!ae) return (xv * yv) % (1 << PW);
    hi  = (yv * (xv >> L)) << L;
    c   = 0;
    orb = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (((xv >> i) & 1) == 1) begin
        c = c + ((yv >> (W - 1 - i)) << (W - 1));
        if (W - 2 - i >= 0 && ((yv >> (W - 2 - i)) & 1) == 1) orb = 1'b1;
      end
    end
    return (hi + c + (orb ? (1 << (W - 1)) : 0)) % (1 << PW);
  endfunction

  task automatic drive(input bit iv, input int xv, input int yv, input bit ae, input bit ordy);
    bus.in_valid  = iv;
    bus.x         = W'(xv);
    bus.y         = W'(yv);
    bus.approx_en = ae;
    bus.out_ready = ordy;
  endtask

  task automatic observe(input int ez, input bit ea);
    exp_t e;
    check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
    check("approx_cnt", bus.approx_cnt, cnt_m);
    if (stall_prev && bus.out_valid) begin
      check("hold_z", bus.z, z_prev);
      check("hold_z_approx", bus.z_approx, za_prev);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out: got z=%0d with no result outstanding, expected none", bus.z);
      end else begin
        e = sbq.pop_front();
        check("z", bus.z, e.z);
        check("z_approx", bus.z_approx, e.a);
        if (lat_chk) check("latency", cyc - e.cyc, STAGES);
        if (e.a) cnt_m = (cnt_m + 1) % (1 << CNTW);
        n_pop++;
      end
    end
    if (bus.in_valid && bus.in_ready) sbq.push_back('{ez, ea, cyc});
    stall_prev = bus.out_valid && !bus.out_ready;
    z_prev     = bus.z;
    za_prev    = bus.z_approx;
    cyc++;
  endtask

  task automatic step(input bit iv, input int xv, input int yv, input bit ae, input bit ordy, input int ez);
    @(posedge clk);
    #1;
    drive(iv, xv, yv, ae, ordy);
    @(negedge clk);
    observe(ez, ae);
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() > 0 && k < 50) begin
      step(1'b0, 0, 0, 1'b0, 1'b1, 0);
      k++;
    end
    check("drain_outstanding", sbq.size(), 0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xv;
    int yv;
    bit ae;
    int pop0;

    tbl[0]  = '{255, 255, 1'b1, 64900};
    tbl[1]  = '{3,   255, 1'b1, 640};
    tbl[2]  = '{3,   255, 1'b0, 765};
    tbl[3]  = '{255, 255, 1'b0, 65025};
    tbl[4]  = '{0,   200, 1'b1, 0};
    tbl[5]  = '{4,   100, 1'b1, 400};
    tbl[6]  = '{1,   128, 1'b1, 128};
    tbl[7]  = '{1,   64,  1'b1, 128};
    tbl[8]  = '{2,   32,  1'b1, 128};
    tbl[9]  = '{1,   63,  1'b1, 0};
    tbl[10] = '{3,   96,  1'b1, 256};
    tbl[11] = '{200, 17,  1'b0, 3400};
    tbl[12] = '{7,   255, 1'b1, 1660};

    // Reset state
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_z", bus.z, 0);
    check("rst_z_approx", bus.z_approx, 0);
    check("rst_approx_cnt", bus.approx_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // First transfer on the first edge after release
    lat_chk = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 7, 255, 1'b1, 1'b1);
    @(negedge clk);
    observe(1660, 1'b1);
    drain();

    // Directed table, back to back
    foreach (tbl[i]) step(1'b1, tbl[i].x, tbl[i].y, tbl[i].ae, 1'b1, tbl[i].ez);
    drain();

    // Stall: out_ready low for three cycles with back-to-back inputs
    lat_chk = 1'b0;
    pop0 = n_pop;
    step(1'b1, 11, 22, 1'b0, 1'b0, 242);
    step(1'b1, 255, 255, 1'b1, 1'b0, 64900);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3, 255, 1'b1, 1'b0, 640);
      check("stall_in_ready", bus.in_ready, 0);
    end
    step(1'b1, 3, 255, 1'b1, 1'b1, 640);
    step(1'b1, 100, 50, 1'b0, 1'b1, 5000);
    drain();
    check("stall_result_count", n_pop - pop0, 4);

    // Random mixed stream with backpressure
    for (int k = 0; k < 2000; k++) begin
      xv = int'($urandom_range(0, 255));
      yv = int'($urandom_range(0, 255));
      ae = 1'($urandom_range(0, 1));
      step($urandom_range(0, 99) < 70, xv, yv, ae, $urandom_range(0, 99) < 60, ref_prod(xv, yv, ae));
    end
    drain();

    // Exact stream at full rate
    lat_chk = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      xv = int'($urandom_range(0, 255));
      yv = int'($urandom_range(0, 255));
      step(1'b1, xv, yv, 1'b0, 1'b1, xv * yv);
    end
    check("throughput_inflight", sbq.size(), STAGES);
    drain();

    // Reset with two results in flight
    lat_chk = 1'b0;
    step(1'b1, 9, 9, 1'b1, 1'b0, ref_prod(9, 9, 1'b1));
    step(1'b1, 200, 201, 1'b1, 1'b0, ref_prod(200, 201, 1'b1));
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_z", bus.z, 0);
    check("mid_rst_z_approx", bus.z_approx, 0);
    check("mid_rst_approx_cnt", bus.approx_cnt, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    sbq.delete();
    cnt_m      = 0;
    stall_prev = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pop0 = n_pop;
    repeat (6) step(1'b0, 0, 0, 1'b0, 1'b1, 0);
    check("no_stale_results", n_pop - pop0, 0);

    // Counter wrap with CNTW=4
    lat_chk = 1'b1;
    for (int k = 0; k < 15; k++) begin
      xv = int'($urandom_range(0, 255));
      yv = int'($urandom_range(0, 255));
      step(1'b1, xv, yv, 1'b1, 1'b1, ref_prod(xv, yv, 1'b1));
    end
    drain();
    check("cnt_preload", bus.approx_cnt, 15);
    step(1'b1, 5, 6, 1'b1, 1'b1, ref_prod(5, 6, 1'b1));
    drain();
    check("cnt_wrap", bus.approx_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 4..16.
REQ-002 Parameter L, default 2: number of low multiplier rows approximated; legal range 0..W-2.
REQ-003 Parameter STAGES, default 2: pipeline depth in cycles; legal range 1..4.
REQ-004 Parameter CNTW, default 16: width of the approximate-result counter.
REQ-005 Port clk, input, 1: single clock; all state on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1: an operand pair is offered.
REQ-008 Port in_ready, output, 1: the block accepts an operand pair this cycle.
REQ-009 Port x, input, W: unsigned multiplier operand.
REQ-010 Port y, input, W: unsigned multiplicand operand.
REQ-011 Port approx_en, input, 1: 1 selects the approximate product, 0 selects the exact product; sampled with x and y.
REQ-012 Port out_valid, output, 1: z is valid.
REQ-013 Port out_ready, input, 1: the downstream block accepts z.
REQ-014 Port z, output, 2W: unsigned product.
REQ-015 Port z_approx, output, 1: z was computed in approximate mode.
REQ-016 Port approx_cnt, output, CNTW: count of approximate results delivered.

Function
REQ-017 An input transfer occurs when in_valid=1 and in_ready=1; an output transfer occurs when out_valid=1 and out_ready=1.
REQ-018 Exact mode: z = x*y, computed at full 2W width.
REQ-019 Approximate mode: z = ((y * x[W-1:L]) << L) + C, mod 2^(2W).
REQ-020 Correction C uses the partial-product rows i<L (row i = y & {W{x[i]}}, bit j at weight 2^(i+j)).
REQ-021 In C, every row bit of weight >= 2^(W-1) is summed exactly.
REQ-022 In C, all row bits of weight 2^(W-2) are ORed together and the result is added at weight 2^(W-1).
REQ-023 In C, all row bits of weight < 2^(W-2) are dropped.
REQ-024 When L=0, the approximate result equals the exact result.
REQ-025 Pipeline: the valid/data registers form STAGES stages. Result latency is exactly STAGES cycles from the input transfer to out_valid when there is no backpressure.
REQ-026 Stall condition: stall = out_valid & ~out_ready. While stalled, every stage holds its contents.
REQ-027 in_ready = ~stall. When not stalled, bubbles advance, so one transfer per cycle is sustained.
REQ-028 z, z_approx and out_valid are registered outputs. z and z_approx stay stable while out_valid=1 and out_ready=0.
REQ-029 approx_cnt increments by 1 on each output transfer with z_approx=1. It wraps from 2^CNTW-1 to 0.
REQ-030 If in_valid=0, or an input is offered during a stall, no state changes except the stage holds described in REQ-026.

Reset
REQ-031 While rst=1, all stage valid bits, out_valid, z, z_approx and approx_cnt are 0, and in_ready is 1.
REQ-032 Reset asserted mid-operation discards all in-flight operands; no partial result is ever presented.
REQ-033 The first input transfer is possible in the first clk edge after rst deasserts.

Structure
REQ-034 Package approx_mult_pkg holds the default values of W, L, STAGES and CNTW, and a function giving the product width 2W.
REQ-035 Sub-module approx_pp_corr is purely combinational. It produces C (REQ-020..REQ-023) from x[L-1:0] and y, and is instantiated once in stage 1.
REQ-036 Stage 1 registers the operands, the mode, the high-row product and C. Later stages register the sum; any extra stages are pure delay.

Verification
REQ-037 W=8, L=2, approx_en=1, x=255, y=255 -> z=64900, z_approx=1, after 2 cycles.
REQ-038 W=8, L=2, approx_en=1, x=3, y=255 -> z=640. The same operands with approx_en=0 -> z=765.
REQ-039 Back-to-back inputs with out_ready held at 0 for 3 cycles -> in_ready=0 during the stall, no result lost or duplicated, order preserved.
REQ-040 Random exact-mode stream of 10^4 vectors -> every z equals x*y, with throughput 1 per cycle when out_ready=1.
REQ-041 Preload approx_cnt to 2^CNTW-1 by driving 2^CNTW-1 approximate transfers (CNTW=4), then one more -> approx_cnt=0.
REQ-042 Assert rst with 2 results in flight -> out_valid=0 immediately; after release, no stale z appears.
